// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button conditioner.
// Each channel synchronises its raw input and filters bounce with a
// stability counter. It produces a clean level plus one-cycle rise and
// fall strobes.
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous button inputs, bit i = channel i
//   btn_level  debounced level (registered)
//   btn_rise   one-cycle pulse when btn_level goes 0->1 (registered)
//   btn_fall   one-cycle pulse when btn_level goes 1->0 (registered)
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_c;
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;

  // Synchroniser chain; stage 0 samples the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Stability filter: count consecutive disagreements, flip on the last one.
  // Any agreement clears the count, so short pulses never reach the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = btn_level;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sync_c[i] == btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = sync_c[i];
        rise_d[i]  = sync_c[i];
        fall_d[i]  = ~sync_c[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      btn_level <= level_d;
      btn_rise  <= rise_d;
      btn_fall  <= fall_d;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (CHANNELS=4, SYNC_STAGES=2,
// STABLE_CYCLES=8). The reference model keeps a history of delayed input
// samples. It flips a channel when the last STABLE_CYCLES samples all
// disagree with the current level.
module tb_debounce_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned K  = 8;
  localparam int unsigned LAT = S + K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_rise;
  logic [CH-1:0] btn_fall;

  debounce_bank #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (S),
    .STABLE_CYCLES (K)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [CH-1:0] hist [$];   // raw samples, most recent first
  logic [CH-1:0] dq   [$];   // post-synchroniser samples, most recent first
  logic [CH-1:0] m_level, m_rise, m_fall;

  // Observations of DUT strobes
  int unsigned rise_cnt [CH];
  int unsigned fall_cnt [CH];
  int unsigned rise_cyc [CH];
  int unsigned fall_cyc [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    hist = {};
    dq   = {};
    for (int i = 0; i < int'(S); i++) hist.push_back('0);
    for (int i = 0; i < int'(K); i++) dq.push_back('0);
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
  endfunction

  function automatic void model_step();
    logic [CH-1:0] d;
    logic          all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d = hist[S-1];
    hist.push_front(btn_in);
    void'(hist.pop_back());
    dq.push_front(d);
    void'(dq.pop_back());
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < int'(CH); c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < int'(K); j++)
        if (dq[j][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c] = ~m_level[c];
        m_rise[c]  = m_level[c];
        m_fall[c]  = ~m_level[c];
      end
    end
  endfunction

  task automatic clear_obs();
    for (int c = 0; c < int'(CH); c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; rise_cyc[c] = 0; fall_cyc[c] = 0;
    end
  endtask

  // One clock: advance model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("level", 32'(btn_level), 32'(m_level));
    check("rise",  32'(btn_rise),  32'(m_rise));
    check("fall",  32'(btn_fall),  32'(m_fall));
    for (int c = 0; c < int'(CH); c++) begin
      if (btn_rise[c]) begin rise_cnt[c]++; rise_cyc[c] = cyc; end
      if (btn_fall[c]) begin fall_cnt[c]++; fall_cyc[c] = cyc; end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges and confirm outputs clear immediately.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_level"}, 32'(btn_level), 32'd0);
    check({tag, "_rise"},  32'(btn_rise),  32'd0);
    check({tag, "_fall"},  32'(btn_fall),  32'd0);
  endtask

  int unsigned c0;
  int unsigned hold [CH];

  initial begin
    model_reset();
    clear_obs();

    // Reset, then idle inputs.
    ticks(3);
    rst_n = 1'b1;
    ticks(50);
    check("idle_level", 32'(btn_level), 32'd0);
    check("idle_rise_cnt", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 32'd0);

    // Clean press and release on channel 0.
    clear_obs();
    btn_in[0] = 1'b1; c0 = cyc;
    ticks(14);
    check("press_rise_cyc", rise_cyc[0], c0 + LAT);
    check("press_rise_cnt", rise_cnt[0], 32'd1);
    check("press_level", 32'(btn_level[0]), 32'd1);
    btn_in[0] = 1'b0; c0 = cyc;
    ticks(14);
    check("release_fall_cyc", fall_cyc[0], c0 + LAT);
    check("release_fall_cnt", fall_cnt[0], 32'd1);

    // Bounce on channel 1: 1,0,1,0 (3 cycles each) then held high.
    clear_obs();
    for (int seg = 0; seg < 4; seg++) begin
      btn_in[1] = (seg % 2 == 0);
      ticks(3);
    end
    btn_in[1] = 1'b1; c0 = cyc;
    ticks(15);
    check("bounce_rise_cyc", rise_cyc[1], c0 + LAT);
    check("bounce_rise_cnt", rise_cnt[1], 32'd1);
    check("bounce_fall_cnt", fall_cnt[1], 32'd0);

    // Short pulses on channel 2: 7 cycles rejected, 8 cycles accepted.
    clear_obs();
    btn_in[2] = 1'b1; ticks(7); btn_in[2] = 1'b0;
    ticks(15);
    check("short7_rise_cnt", rise_cnt[2], 32'd0);
    check("short7_level", 32'(btn_level[2]), 32'd0);
    btn_in[2] = 1'b1; ticks(8); btn_in[2] = 1'b0;
    ticks(25);
    check("short8_rise_cnt", rise_cnt[2], 32'd1);
    check("short8_fall_cnt", fall_cnt[2], 32'd1);

    // Simultaneous press on all channels.
    btn_in = '0; ticks(15);
    clear_obs();
    btn_in = '1; c0 = cyc;
    ticks(LAT);
    for (int c = 0; c < int'(CH); c++) check("simul_rise_cyc", rise_cyc[c], c0 + LAT);
    check("simul_rise_now", 32'(btn_rise), 32'hF);
    // Reset while the strobe is high drops it; held inputs rise again.
    async_reset("midstrobe");
    ticks(2);
    rst_n = 1'b1; c0 = cyc;
    clear_obs();
    ticks(LAT + 3);
    for (int c = 0; c < int'(CH); c++) check("rerise_cyc", rise_cyc[c], c0 + LAT);

    // Reset mid-count on channel 3.
    btn_in = '0; ticks(15);
    clear_obs();
    btn_in[3] = 1'b1;
    ticks(5);
    async_reset("midcount");
    ticks(2);
    check("midcount_no_rise", rise_cnt[3], 32'd0);
    rst_n = 1'b1; c0 = cyc;
    ticks(LAT + 4);
    check("midcount_rise_cyc", rise_cyc[3], c0 + LAT);
    check("midcount_rise_cnt", rise_cnt[3], 32'd1);

    // Randomised traffic with occasional resets, checked every cycle.
    for (int c = 0; c < int'(CH); c++) hold[c] = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < int'(CH); c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rand_reset");
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel push-button conditioner for the board's buttons and switches.
- Per channel: synchronises an asynchronous input, suppresses bounce with a stability counter, and outputs a clean level plus one-cycle rise and fall strobes.
- Sits between the top-level pins and the game control logic (paddle moves, serve/reset), replacing per-button shift-register debouncers.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- STABLE_CYCLES, 1000000, consecutive clk cycles the synchronised input must differ from btn_level before btn_level flips (>=1; 10 ms at 100 MHz).
- CNT_W, derived localparam $clog2(STABLE_CYCLES+1), counter width; not user-set.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_in  input  CHANNELS  raw asynchronous button inputs, bit i = channel i
- btn_level  output  CHANNELS  debounced level, registered
- btn_rise  output  CHANNELS  one-cycle pulse when btn_level goes 0->1, registered
- btn_fall  output  CHANNELS  one-cycle pulse when btn_level goes 1->0, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all synchroniser flops, counters, btn_level, btn_rise and btn_fall are 0. Release takes effect on the next clk edge. No pulses are generated on reset release itself.
- Synchroniser: a chain of SYNC_STAGES flops per channel. sync_i is the last stage.
- Per-channel filter, evaluated every edge:
  - sync_i == btn_level[i]: counter <= 0.
  - sync_i != btn_level[i] and counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync_i != btn_level[i] and counter == STABLE_CYCLES-1: btn_level[i] <= sync_i, counter <= 0, and btn_rise[i] or btn_fall[i] <= 1 (matching direction) on the same edge.
- Strobes: btn_rise/btn_fall are high for exactly one cycle. Both are low on every other edge. They are never high together on the same channel.
- Latency: btn_in changes before edge 0 and is held. btn_level and the strobe change on edge SYNC_STAGES+STABLE_CYCLES, i.e. 2+STABLE_CYCLES with defaults.
- Glitch rejection: any return of sync_i to btn_level before the count completes clears the counter. A pulse shorter than STABLE_CYCLES cycles (post-synchroniser) never reaches btn_level.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- STABLE_CYCLES=1: btn_level follows sync with one edge delay; a strobe accompanies every flip.
- Reset mid-count or mid-strobe: all state clears immediately, and an in-flight strobe is dropped. An input still high after release yields btn_rise after full latency, because btn_level restarts at 0.

Test Plan (CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=8):
- Reset then btn_in=4'b0000 for 50 cycles -> btn_level=0, no strobes; assert rst_n low mid-sim -> outputs 0 asynchronously, before the next clk edge.
- Clean press: btn_in[0] 0->1 before edge 0, held -> btn_level[0]=1 and btn_rise[0]=1 at edge 10 only. Release -> btn_fall[0]=1 ten edges after the change.
- Bounce: btn_in[1] toggles 1,0,1,0,1 with 3-cycle segments, then held high -> exactly one btn_rise[1], 10 edges after the final 0->1; btn_level[1] never glitches.
- Short pulse: btn_in[2] high for 7 cycles then low -> btn_level[2] stays 0, no strobes. Repeat with 8 cycles -> a single rise followed later by a single fall.
- Simultaneous: btn_in 0000->1111 on one edge -> all four btn_rise bits high on the same edge 10, one cycle wide.
- Reset mid-operation: btn_in[3] held high, rst_n pulsed low at edge 5 and released -> no strobe before release; btn_rise[3] occurs 10 edges after release.
